// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared size encodings, FSM states and helpers for the data-memory LSU
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } lsu_state_t;

  // Ceiling log2; clogb2(1) = 0.
  function automatic int clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - core request/response channels and mem0 port of the LSU
interface dmem_lsu_if #(parameter int N = 1024);
  localparam int n = dmem_lsu_pkg::clogb2(N);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;

  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  logic [n-1:0]  mem0_dr;
  logic [31:0]   mem0_dw;
  logic          mem0_ena;
  logic          mem0_rw;
  logic [31:0]   mem0_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem0_dr, mem0_dw, mem0_ena, mem0_rw,
    input  mem0_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem0_dr, mem0_dw, mem0_ena, mem0_rw,
    output mem0_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sgn,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  always_comb begin
    sh        = 5'd0;
    mask      = 32'hFFFF_FFFF;
    load_data = word;
    case (size)
      SZ_BYTE: begin
        sh   = {lane, 3'b000};
        mask = 32'h0000_00FF << sh;
      end
      SZ_HALF: begin
        sh   = {lane[1], 4'b0000};
        mask = 32'h0000_FFFF << sh;
      end
      default: ;
    endcase
    shifted = word >> sh;
    case (size)
      SZ_BYTE: load_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
    merge_data = (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit driving the single-port data memory, RMW for sub-word stores
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int N = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_lsu_if.slave    bus
);
  localparam int n = clogb2(N);

  lsu_state_t   state, state_nxt;
  logic         we_q, sgn_q, err_q;
  logic [1:0]   size_q, lane_q;
  logic [n-1:0] idx_q;
  logic [31:0]  wdata_q, merged_q, rdata_q;
  logic         req_err;
  logic [31:0]  load_data, merge_data;

  always_comb begin
    req_err = (bus.req_size == 2'd3)
           || (bus.req_size == SZ_HALF && bus.req_addr[0])
           || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
           || (bus.req_addr[31:n+2] != '0);
  end

  lsu_align u_align (
    .word       (bus.mem0_rdata),
    .wdata      (wdata_q),
    .size       (size_q),
    .lane       (lane_q),
    .sgn        (sgn_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem0_ena   = 1'b0;
    bus.mem0_rw    = 1'b0;
    bus.mem0_dw    = 32'd0;
    bus.mem0_dr    = idx_q;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem0_ena = 1'b1;
        if (we_q && size_q == SZ_WORD) begin
          bus.mem0_rw = 1'b1;
          bus.mem0_dw = wdata_q;
          state_nxt   = RESP;
        end else if (we_q) begin
          state_nxt = WRITE;
        end else begin
          state_nxt = RESP;
        end
      end
      WRITE: begin
        bus.mem0_ena = 1'b1;
        bus.mem0_rw  = 1'b1;
        bus.mem0_dw  = merged_q;
        state_nxt    = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must block a write even when it lands mid-operation.
    if (!rst_n) begin
      bus.mem0_ena = 1'b0;
      bus.mem0_rw  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      sgn_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      lane_q   <= 2'd0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      merged_q <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q    <= bus.req_we;
          sgn_q   <= bus.req_signed;
          size_q  <= bus.req_size;
          lane_q  <= bus.req_addr[1:0];
          idx_q   <= bus.req_addr[n+1:2];
          wdata_q <= bus.req_wdata;
          err_q   <= req_err;
        end
        ACCESS: begin
          if (!we_q)                 rdata_q  <= load_data;
          else if (size_q != SZ_WORD) merged_q <= merge_data;
        end
        RESP: if (bus.resp_ready) begin
          rdata_q <= 32'd0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed and randomized checks of dmem_lsu against a byte-level memory model
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  localparam int N = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_lsu_if #(.N(N)) bus();

  dmem_lsu #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [31:0] mem [N];
  logic [31:0] ref_mem [N];
  logic        mem_init = 1'b1;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign bus.mem0_rdata = mem[bus.mem0_dr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < N; i++) mem[i] <= seed_word(i);
    end else if (bus.mem0_ena && bus.mem0_rw) begin
      mem[bus.mem0_dr] <= bus.mem0_dw;
    end
  end

  int checks = 0;
  int errors = 0;

  logic        ena_log [8];
  logic        rw_log  [8];
  logic [31:0] dr_log  [8];
  logic [31:0] dw_log  [8];
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-granular model: stores overwrite bytes, loads gather bytes then extend.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    int     nbytes, off, idx;
    longint val;
    rdata = 32'd0;
    lat   = 1;
    if (size == 2'd3) begin
      err = 1'b1;
      return;
    end
    nbytes = 1 << size;
    off    = int'(addr % 4);
    err    = (int'(addr % 4) % nbytes != 0) || (addr >= 32'(4 * N));
    if (err) return;
    idx = int'(addr / 4);
    if (we) begin
      for (int i = 0; i < nbytes; i++) ref_mem[idx][8*(off+i) +: 8] = wdata[8*i +: 8];
      lat = (nbytes < 4) ? 3 : 2;
    end else begin
      val = 0;
      for (int i = 0; i < nbytes; i++) val = val | (longint'(ref_mem[idx][8*(off+i) +: 8]) << (8*i));
      if (sgn && nbytes < 4 && val >= (longint'(1) << (8*nbytes - 1))) val = val - (longint'(1) << (8*nbytes));
      rdata = val[31:0];
      lat   = 2;
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic [31:0] exp_rdata, held;
    logic        exp_err, ena_seen, done;
    int          exp_lat, lat;
    model(we, size, sgn, addr, wdata, exp_rdata, exp_err, exp_lat);
    for (int i = 0; i < 8; i++) begin
      ena_log[i] = 1'b0; rw_log[i] = 1'b0; dr_log[i] = 32'd0; dw_log[i] = 32'd0;
    end
    bus.resp_ready = (hold == 0);
    check({tag, ":req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    ena_seen = bus.mem0_ena;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat  = 1;
    done = 1'b0;
    while (!done && lat < 8) begin
      ena_log[lat] = bus.mem0_ena;
      rw_log[lat]  = bus.mem0_rw;
      dr_log[lat]  = 32'(bus.mem0_dr);
      dw_log[lat]  = bus.mem0_dw;
      ena_seen     = ena_seen | bus.mem0_ena;
      if (bus.resp_valid) done = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!done) begin
      check({tag, ":timeout"}, 32'd0, 32'd1);
      bus.resp_ready = 1'b1;
      return;
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":err"}, 32'(bus.resp_err), 32'(exp_err));
    check({tag, ":rdata"}, bus.resp_rdata, exp_rdata);
    if (exp_err) check({tag, ":no_ena"}, 32'(ena_seen), 32'd0);
    last_rdata = bus.resp_rdata;
    last_err   = bus.resp_err;
    held       = bus.resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, ":hold_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, ":hold_rdata"}, bus.resp_rdata, held);
      check({tag, ":hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check({tag, ":cleared_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, ":cleared_rdata"}, bus.resp_rdata, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_we, r_sgn;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;
    int          bad;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b1;
    for (int i = 0; i < N; i++) ref_mem[i] = seed_word(i);
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_mem_ena", 32'(bus.mem0_ena), 32'd0);
    mem_init = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    do_req("sw", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    check("sw_rw_t1", 32'(rw_log[1]), 32'd1);
    check("sw_dr_t1", dr_log[1], 32'd4);
    check("sw_dw_t1", dw_log[1], 32'hDEAD_BEEF);
    do_req("lw", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 0);
    check("lw_value", last_rdata, 32'hDEAD_BEEF);

    do_req("sw2", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344, 0);
    do_req("sb", 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h0000_00AA, 0);
    check("sb_read_ena", 32'(ena_log[1]), 32'd1);
    check("sb_read_rw", 32'(rw_log[1]), 32'd0);
    check("sb_write_rw", 32'(rw_log[2]), 32'd1);
    check("sb_write_dw", dw_log[2], 32'hAA22_3344);
    do_req("lw_sb", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 0);
    check("lw_sb_value", last_rdata, 32'hAA22_3344);
    do_req("lb_s", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'd0, 0);
    check("lb_s_value", last_rdata, 32'hFFFF_FFAA);
    do_req("lb_u", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'd0, 0);
    check("lb_u_value", last_rdata, 32'h0000_00AA);

    do_req("sw3", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8001_0000, 0);
    do_req("lh_s", 1'b0, SZ_HALF, 1'b1, 32'h12, 32'd0, 0);
    check("lh_s_value", last_rdata, 32'hFFFF_8001);

    do_req("lh_mis", 1'b0, SZ_HALF, 1'b0, 32'h11, 32'd0, 0);
    check("lh_mis_err", 32'(last_err), 32'd1);
    do_req("sw_oor", 1'b1, SZ_WORD, 1'b0, 32'h1000, 32'hCAFE_F00D, 0);
    check("sw_oor_err", 32'(last_err), 32'd1);
    check("sw_oor_mem0", mem[0], seed_word(0));

    do_req("bp", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 5);

    // Reset while the sub-word write cycle is on the bus.
    bus.resp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_BYTE; bus.req_signed = 1'b0;
    bus.req_addr = 32'h21; bus.req_wdata = 32'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstw_in_write", 32'(bus.mem0_rw), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_ena_forced", 32'(bus.mem0_ena), 32'd0);
    check("rstw_rw_forced", 32'(bus.mem0_rw), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rstw_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rstw_req_ready", 32'(bus.req_ready), 32'd1);
    check("rstw_mem_unchanged", mem[8], ref_mem[8]);
    @(negedge clk);

    for (int k = 0; k < 150; k++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_sgn   = 1'($urandom_range(0, 1));
      r_addr  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 11) == 0) r_addr = r_addr | (32'd1 << $urandom_range(12, 31));
      r_wdata = $urandom;
      do_req($sformatf("rnd%0d", k), r_we, r_size, r_sgn, r_addr, r_wdata,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_final_words_differing", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
